ram_latency_model: RTL and testbench

RAM_LATENCY_MODEL -- requirements
Module: ram_latency_model

---
 rtl/cache_pkg.sv | 15 +
 rtl/latency_counter.sv | 25 ++
 rtl/ram_latency_model.sv | 114 +++++++++++
 tb/tb_ram_latency_model.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the cache RAM model.
package cache_pkg;

    localparam int   WORD_W     = 32;
    localparam int   SIZE_RAM   = 4096;
    localparam int   ADDR_BITS  = 12;
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/latency_counter.sv
// Loadable 4-bit down-counter with a zero flag, used to time RAM operations.
module latency_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    // Load takes priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/ram_latency_model.sv
// Word-addressed RAM that completes each request a fixed number of cycles
// after accepting it. A request is any change of {address, mode, data}
// relative to the last accepted one while the model is idle.
module ram_latency_model #(
    parameter int SIZE_RAM  = cache_pkg::SIZE_RAM,
    parameter int ADDR_BITS = cache_pkg::ADDR_BITS,
    parameter int LATENCY   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [cache_pkg::WORD_W-1:0] data,
    input  logic [cache_pkg::WORD_W-1:0] address,
    input  logic                        mode,
    output logic [cache_pkg::WORD_W-1:0] out,
    output logic                        response
);
    import cache_pkg::*;

    state_t                state;
    state_t                next_state;
    logic [ADDR_BITS-1:0]  addr_in;
    logic [ADDR_BITS-1:0]  rec_addr;
    logic                  rec_mode;
    logic [WORD_W-1:0]     rec_data;
    logic                  new_req;
    logic                  load;
    logic                  dec;
    logic                  complete;
    logic                  zero;
    logic [3:0]            unused_count;
    logic                  unused_addr_hi;
    logic [WORD_W-1:0]     rd_word;

    // Storage holds (value XOR index) so an all-zero power-up image reads
    // back as mem[i] = i without any reset or load sequence touching it.
    logic [WORD_W-1:0] mem [SIZE_RAM] = '{default: '0};

    assign addr_in        = address[ADDR_BITS-1:0];
    assign unused_addr_hi = ^address[WORD_W-1:ADDR_BITS];
    assign new_req        = (addr_in != rec_addr) || (mode != rec_mode) || (data != rec_data);
    assign rd_word        = mem[rec_addr] ^ WORD_W'(rec_addr);
    assign response       = (state == BUSY);

    latency_counter u_latency_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (4'(LATENCY - 1)),
        .dec        (dec),
        .count      (unused_count),
        .zero       (zero)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept only from IDLE, complete only when the counter hits zero.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        dec        = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (new_req) begin
                    load       = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (zero) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end else begin
                    dec = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request record and read-data register; both cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_addr <= '0;
            rec_mode <= MODE_READ;
            rec_data <= '0;
            out      <= '0;
        end else begin
            if (load) begin
                rec_addr <= addr_in;
                rec_mode <= mode;
                rec_data <= data;
            end
            if (complete) begin
                out <= (rec_mode == MODE_WRITE) ? rec_data : rd_word;
            end
        end
    end

    // Memory is written only at completion, so an aborted write leaves it untouched.
    always_ff @(posedge clk) begin
        if (complete && (rec_mode == MODE_WRITE)) begin
            mem[rec_addr] <= rec_data ^ WORD_W'(rec_addr);
        end
    end

endmodule

// File: tb/tb_ram_latency_model.sv
// Scoreboard bench for ram_latency_model: expected read data is queued when a
// request is driven and compared when the busy period ends.
module tb_ram_latency_model;

    localparam int LATENCY = 4;
    localparam int SIZE    = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [31:0] address;
    logic        mode;
    logic [31:0] out;
    logic        response;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl [SIZE];

    ram_latency_model #(
        .SIZE_RAM  (4096),
        .ADDR_BITS (12),
        .LATENCY   (LATENCY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .address  (address),
        .mode     (mode),
        .out      (out),
        .response (response)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after inputs change at a falling edge; 'seen' is the number
    // of busy cycles already observed by the caller.
    task automatic wait_done(input string tag, input int seen);
        int gap  = 0;
        int busy = seen;
        logic [31:0] exp;
        @(negedge clk);
        while (!response && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        while (response && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        chk({tag, "_start"}, gap, 0);
        chk({tag, "_busy"}, busy, LATENCY);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chk({tag, "_out"}, out, exp);
    endtask

    task automatic req(input string tag, input logic [31:0] a, input logic m, input logic [31:0] d);
        int idx;
        idx     = int'(a % SIZE);
        address = a;
        mode    = m;
        data    = d;
        if (m) begin
            mdl[idx] = d;
            exp_q.push_back(d);
        end else begin
            exp_q.push_back(mdl[idx]);
        end
        wait_done(tag, 0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < SIZE; i++) mdl[i] = 32'(i);
        rst_n   = 1'b0;
        address = '0;
        mode    = 1'b0;
        data    = '0;
        repeat (3) @(negedge clk);
        chk("rst_resp", {31'd0, response}, 32'd0);
        chk("rst_out", out, 32'd0);
        rst_n = 1'b1;

        // Inputs equal to the reset record must not start a request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'd0, response}, 32'd0);
        end

        req("rd5", 32'd5, 1'b0, 32'd0);

        // Holding the same inputs produces no new busy period.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("repeat_idle", {31'd0, response}, 32'd0);
        end
        chk("repeat_out", out, 32'd5);

        req("wr7", 32'd7, 1'b1, 32'hDEADBEEF);
        req("rd7", 32'd7, 1'b0, 32'hDEADBEEF);
        req("wr7_a", 32'd7, 1'b1, 32'h00000011);
        req("wr7_b", 32'd7, 1'b1, 32'h00000022);
        req("rd7_b", 32'd7, 1'b0, 32'h00000022);

        req("wrap_rd", 32'd4105, 1'b0, 32'd0);
        req("wrap_wr", 32'd4100, 1'b1, 32'h000000AA);
        req("wrap_rd4", 32'd4, 1'b0, 32'h000000AA);
        req("wrap_rd1", 32'd4097, 1'b0, 32'h000000AA);

        // Input change during busy is ignored, then accepted after one idle cycle.
        address = 32'd10;
        mode    = 1'b0;
        data    = 32'd0;
        exp_q.push_back(mdl[10]);
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (response) seen++;
        end
        address = 32'd20;
        exp_q.push_back(mdl[20]);
        wait_done("busy_ign10", seen);
        chk("busy_ign_gap", {31'd0, response}, 32'd0);
        wait_done("busy_ign20", 0);

        // Reset during a write aborts it and leaves memory unchanged.
        address = 32'd3;
        mode    = 1'b1;
        data    = 32'h00000055;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_busy", {31'd0, response}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_resp", {31'd0, response}, 32'd0);
        chk("rstw_out", out, 32'd0);
        address = 32'd3;
        mode    = 1'b0;
        data    = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mdl[3]);
        wait_done("rstw_rd3", 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
